// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down-counter sequencer and its counting core.
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } ctrl_state_t;

    localparam int DEF_W = 4;

endpackage

// File: rtl/down_counter_core.sv
// Loadable down-counter datapath: synchronous zero, load and decrement, in that priority.
module down_counter_core
    import down_counter_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic         zero_sync,
    output logic [W-1:0] count,
    output logic         is_one
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (zero_sync) begin
            count_d = '0;
        end else if (ld) begin
            count_d = ld_val;
        end else if (en) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign is_one = (count_q == W'(1));

endmodule

// File: rtl/down_counter_ctrl.sv
// Countdown sequencer: FSM, load register and done pulse driving a down_counter_core.
// Optional AUTO_RELOAD_EN makes the terminal step reload load_reg and keep running.
module down_counter_ctrl
    import down_counter_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         start,
    input  logic [W-1:0] load_val,
    input  logic         pause,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] count
);

    ctrl_state_t  state_q, state_d;
    logic [W-1:0] load_reg_q, load_reg_d;
    logic         done_q, done_d;

    logic         core_ld;
    logic         core_en;
    logic         core_zero;
    logic [W-1:0] core_ld_val;
    logic         core_is_one;

    // Outside IDLE the only load source is the latched start value (reload path).
    assign core_ld_val = (state_q == IDLE) ? load_val : load_reg_q;

    always_comb begin
        state_d    = state_q;
        load_reg_d = load_reg_q;
        done_d     = 1'b0;
        core_ld    = 1'b0;
        core_en    = 1'b0;
        core_zero  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        core_ld    = 1'b1;
                        load_reg_d = load_val;
                        state_d    = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    core_zero = 1'b1;
                    state_d   = IDLE;
                end else if (core_is_one) begin
`ifdef AUTO_RELOAD_EN
                    core_ld = 1'b1;
                    done_d  = 1'b1;
`else
                    core_zero = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
`endif
                end else if (!pause) begin
                    core_en = 1'b1;
                end else begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (abort) begin
                    core_zero = 1'b1;
                    state_d   = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                core_zero = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            load_reg_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_reg_q <= load_reg_d;
            done_q     <= done_d;
        end
    end

    down_counter_core #(.W(W)) u_core (
        .clk       (clk),
        .clear     (clear),
        .ld        (core_ld),
        .ld_val    (core_ld_val),
        .en        (core_en),
        .zero_sync (core_zero),
        .count     (count),
        .is_one    (core_is_one)
    );

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
